// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and iterative-unit modes for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_FWD  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SLL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // Working mode of the iterative unit
  localparam logic [1:0] IT_MUL = 2'd0;
  localparam logic [1:0] IT_SLL = 2'd1;
  localparam logic [1:0] IT_SRA = 2'd2;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative working registers for MUL (shift-add) and multi-bit shifts
// (one bit per step). o_res is the value the current step produces, so the
// top can capture it on the final step edge.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_last,
  output logic [WIDTH-1:0] o_res
);

  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_mode;

  logic [WIDTH-1:0] w_next_acc, w_next_a;

  // Next-step values: accumulate uses A before it shifts; SRA keeps the sign bit
  always_comb begin
    w_next_acc = r_acc + (r_b[0] ? r_a : '0);
    if (r_mode == IT_SRA) w_next_a = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
    else                  w_next_a = {r_a[WIDTH-2:0], 1'b0};
    o_res  = (r_mode == IT_MUL) ? w_next_acc : w_next_a;
    o_last = (r_cnt == CNT_W'(1));
  end

  // Load on acceptance, then one step per EXEC cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mode <= IT_MUL;
    end else if (i_load) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= i_cnt;
      r_mode <= i_mode;
    end else if (i_step) begin
      r_a    <= w_next_a;
      r_b    <= r_b >> 1;
      r_acc  <= w_next_acc;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with START/BUSY/DONE handshake. Simple ops complete on the
// accepting edge; MUL and nonzero shifts run in alu_iter_unit while BUSY=1.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int CNT_W   = SHAMT_W + 1;  // must hold WIDTH for MUL

  state_t r_state;

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_sum, w_comb, w_iter_res;
  logic               w_add_ovf, w_iter_op, w_load, w_step, w_last;
  logic [1:0]         w_mode;
  logic [CNT_W-1:0]   w_cnt_init;

  // Decode and single-cycle datapath, all from the live inputs at acceptance
  always_comb begin
    w_shamt   = DATA2[SHAMT_W-1:0];
    w_sum     = DATA1 + DATA2;
    w_add_ovf = (DATA1[WIDTH-1] == DATA2[WIDTH-1]) && (w_sum[WIDTH-1] != DATA1[WIDTH-1]);
    w_iter_op = (SELECT == OP_MUL) ||
                (((SELECT == OP_SLL) || (SELECT == OP_SRA)) && (w_shamt != '0));
    w_load    = (r_state == S_IDLE) && START && w_iter_op;
    w_step    = (r_state == S_EXEC);
    if (SELECT == OP_MUL)      w_mode = IT_MUL;
    else if (SELECT == OP_SLL) w_mode = IT_SLL;
    else                       w_mode = IT_SRA;
    w_cnt_init = (SELECT == OP_MUL) ? CNT_W'(WIDTH) : {1'b0, w_shamt};
    case (SELECT)
      OP_FWD:         w_comb = DATA2;
      OP_ADD:         w_comb = w_sum;
      OP_AND:         w_comb = DATA1 & DATA2;
      OP_OR:          w_comb = DATA1 | DATA2;
      OP_SLL, OP_SRA: w_comb = DATA1;   // only reached with amount 0
      default:        w_comb = '0;      // reserved (MUL never lands here)
    endcase
  end

  alu_iter_unit #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .i_clk  (CLK),
    .i_rst  (RESET),
    .i_load (w_load),
    .i_step (w_step),
    .i_mode (w_mode),
    .i_a    (DATA1),
    .i_b    (DATA2),
    .i_cnt  (w_cnt_init),
    .o_last (w_last),
    .o_res  (w_iter_res)
  );

  // Control FSM with registered result, flags and handshake outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      RESULT  <= '0;
      ZERO    <= 1'b1;
      OVF     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            if (w_iter_op) begin
              r_state <= S_EXEC;
              BUSY    <= 1'b1;
            end else begin
              RESULT <= w_comb;
              ZERO   <= (w_comb == '0);
              OVF    <= (SELECT == OP_ADD) && w_add_ovf;
              DONE   <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          // START is ignored here; the op in flight runs to completion
          if (w_last) begin
            r_state <= S_IDLE;
            RESULT  <= w_iter_res;
            ZERO    <= (w_iter_res == '0);
            OVF     <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench: directed table, random ops against an arithmetic
// reference model, and hand-written handshake/reset sequences. A second
// instance at WIDTH=16 covers the wide multiply latency.
module tb_alu_multicycle;

  localparam logic [2:0] FWD = 3'd0, ADD = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         MUL = 3'd4, SLL = 3'd5, SRA = 3'd6, RSV = 3'd7;

  logic       CLK = 1'b0;
  logic       RESET, START;
  logic [7:0] DATA1, DATA2, RESULT;
  logic [2:0] SELECT;
  logic       ZERO, OVF, BUSY, DONE;

  logic        w_reset, w_start, w_zero, w_ovf, w_busy, w_done;
  logic [15:0] w_d1, w_d2, w_res;
  logic [2:0]  w_sel;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  alu_multicycle #(.WIDTH(8)) dut8 (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO), .OVF(OVF), .BUSY(BUSY), .DONE(DONE)
  );

  alu_multicycle #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RESET(w_reset), .START(w_start), .DATA1(w_d1), .DATA2(w_d2),
    .SELECT(w_sel), .RESULT(w_res), .ZERO(w_zero), .OVF(w_ovf), .BUSY(w_busy), .DONE(w_done)
  );

  typedef struct {
    logic [2:0] sel;
    logic [7:0] a, b, res;
    logic       z, o;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: value semantics of each opcode on 8-bit unsigned/signed numbers
  function automatic void model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] res, output logic o, output int lat);
    int ua, ub, sa, sb, k, r;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    k  = ub % 8;
    o  = 1'b0; lat = 1; r = 0;
    case (sel)
      FWD:  r = ub;
      ADD:  begin r = (ua + ub) % 256; o = ((sa + sb) > 127) || ((sa + sb) < -128); end
      AND_: r = int'(a & b);
      OR_:  r = int'(a | b);
      MUL:  begin r = (ua * ub) % 256; lat = 9; end
      SLL:  begin r = (ua * (2 ** k)) % 256; lat = k + 1; end
      SRA:  begin r = (sa >>> k) & 255; lat = k + 1; end
      default: r = 0;
    endcase
    res = 8'(r);
  endfunction

  // Issue one op at a negedge; returns at the negedge of the DONE cycle
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output logic z, output logic o,
                        output int lat, output int bcnt);
    SELECT = sel; DATA1 = a; DATA2 = b; START = 1'b1;
    @(negedge CLK);
    START = 1'b0; DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
    lat = 1; bcnt = 0;
    while (!DONE && lat < 40) begin
      if (BUSY) bcnt++;
      @(negedge CLK);
      lat++;
    end
    res = RESULT; z = ZERO; o = OVF;
  endtask

  initial begin
    logic [7:0] res, eres;
    logic       z, o, eo;
    int         lat, elat, bcnt, t;
    logic [2:0] rs;
    logic [7:0] ra, rb;

    RESET = 1'b1; START = 1'b0; DATA1 = '0; DATA2 = '0; SELECT = '0;
    w_reset = 1'b1; w_start = 1'b0; w_d1 = '0; w_d2 = '0; w_sel = '0;
    repeat (3) @(negedge CLK);
    check("rst_result", 32'(RESULT), 32'h0);
    check("rst_zero",   32'(ZERO),   32'h1);
    check("rst_ovf",    32'(OVF),    32'h0);
    check("rst_busy",   32'(BUSY),   32'h0);
    check("rst_done",   32'(DONE),   32'h0);
    RESET = 1'b0; w_reset = 1'b0;
    @(negedge CLK);

    // Directed table
    tbl.push_back('{ADD,  8'h05, 8'hFD, 8'h02, 1'b0, 1'b0, 1});
    tbl.push_back('{ADD,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1});
    tbl.push_back('{MUL,  8'h0D, 8'h0B, 8'h8F, 1'b0, 1'b0, 9});
    tbl.push_back('{MUL,  8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 9});
    tbl.push_back('{SRA,  8'h90, 8'h03, 8'hF2, 1'b0, 1'b0, 4});
    tbl.push_back('{SLL,  8'h81, 8'h08, 8'h81, 1'b0, 1'b0, 1});
    tbl.push_back('{RSV,  8'h12, 8'h34, 8'h00, 1'b1, 1'b0, 1});
    tbl.push_back('{AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1});
    tbl.push_back('{OR_,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1});
    tbl.push_back('{FWD,  8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1});
    tbl.push_back('{SLL,  8'h81, 8'h01, 8'h02, 1'b0, 1'b0, 2});
    tbl.push_back('{SRA,  8'h7F, 8'h07, 8'h00, 1'b1, 1'b0, 8});
    tbl.push_back('{ADD,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1});
    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, res, z, o, lat, bcnt);
      check($sformatf("vec%0d_res", i),  32'(res), 32'(tbl[i].res));
      check($sformatf("vec%0d_zero", i), 32'(z),   32'(tbl[i].z));
      check($sformatf("vec%0d_ovf", i),  32'(o),   32'(tbl[i].o));
      check($sformatf("vec%0d_lat", i),  lat,      tbl[i].lat);
      check($sformatf("vec%0d_busy", i), bcnt,     tbl[i].lat - 1);
    end

    // DONE is a single pulse
    @(negedge CLK);
    check("done_pulse", 32'(DONE), 32'h0);

    // Random ops, back-to-back, against the model
    for (int i = 0; i < 60; i++) begin
      rs = 3'($urandom); ra = 8'($urandom); rb = 8'($urandom);
      model(rs, ra, rb, eres, eo, elat);
      run_op(rs, ra, rb, res, z, o, lat, bcnt);
      check($sformatf("rnd%0d_op%0d_res", i, rs), 32'(res), 32'(eres));
      check($sformatf("rnd%0d_zero", i), 32'(z),   32'(eres == 8'h00));
      check($sformatf("rnd%0d_ovf", i),  32'(o),   32'(eo));
      check($sformatf("rnd%0d_lat", i),  lat,      elat);
    end

    // Input activity while BUSY must not disturb the running MUL
    SELECT = MUL; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
    @(negedge CLK);
    lat = 1;
    while (!DONE && lat < 40) begin
      START = 1'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = ADD;
      @(negedge CLK);
      lat++;
    end
    START = 1'b0;
    check("busy_ignore_res", 32'(RESULT), 32'h8F);
    check("busy_ignore_lat", lat, 9);
    // START in the DONE cycle is accepted
    run_op(AND_, 8'hF0, 8'h3C, res, z, o, lat, bcnt);
    check("b2b_res", 32'(res), 32'h30);
    check("b2b_lat", lat, 1);

    // Reset during MUL: abandoned, no DONE afterwards
    run_op(FWD, 8'h00, 8'h77, res, z, o, lat, bcnt);
    SELECT = MUL; DATA1 = 8'h0D; DATA2 = 8'h0B; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("midrst_result", 32'(RESULT), 32'h0);
    check("midrst_zero",   32'(ZERO),   32'h1);
    check("midrst_busy",   32'(BUSY),   32'h0);
    t = 0;
    for (int c = 0; c < 10; c++) begin
      if (DONE) t++;
      @(negedge CLK);
    end
    check("midrst_no_done", t, 0);
    run_op(FWD, 8'h00, 8'h5A, res, z, o, lat, bcnt);
    check("postrst_fwd", 32'(res), 32'h5A);

    // WIDTH=16 multiply
    w_sel = MUL; w_d1 = 16'h1234; w_d2 = 16'h0010; w_start = 1'b1;
    @(negedge CLK);
    w_start = 1'b0; w_d1 = 16'hFFFF; w_d2 = 16'hFFFF;
    lat = 1; bcnt = 0;
    while (!w_done && lat < 60) begin
      if (w_busy) bcnt++;
      @(negedge CLK);
      lat++;
    end
    check("w16_res",  32'(w_res), 32'h2340);
    check("w16_lat",  lat, 17);
    check("w16_busy", bcnt, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, registered successor to the single-cycle 8-bit CPU ALU, with generic WIDTH and added operations.
- Adds iterative multiply and multi-bit shifts, a START/BUSY/DONE handshake, and ZERO and OVF flags.
- Sits between the register file and the writeback mux. The control unit issues START and stalls the PC while BUSY=1.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥2 and a power of 2.
- SHAMT_W, $clog2(WIDTH), local (derived, not overridable); shift-amount field width taken from DATA2[SHAMT_W-1:0].

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only when BUSY=0
- DATA1  input  WIDTH  operand A
- DATA2  input  WIDTH  operand B / shift amount
- SELECT  input  3  opcode
- RESULT  output  WIDTH  registered result; holds until next completion
- ZERO  output  1  registered, RESULT==0
- OVF  output  1  registered two's-complement overflow of ADD; 0 for all other ops
- BUSY  output  1  high while an iterative op is in progress
- DONE  output  1  one-cycle pulse when RESULT/flags update

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RESET.
- Reset values: RESULT=0, ZERO=1, OVF=0, BUSY=0, DONE=0, state=IDLE, internal registers=0.
- Reset mid-operation abandons the op. No DONE is produced and RESULT is forced to 0.
- Opcodes:
  - 000 FWD: DATA2
  - 001 ADD: DATA1+DATA2 modulo 2^WIDTH. Subtraction is done by the caller supplying a negated DATA2.
  - 010 AND
  - 011 OR
  - 100 MUL: unsigned, low WIDTH bits of the product
  - 101 SLL: logical left shift of DATA1 by DATA2[SHAMT_W-1:0]
  - 110 SRA: arithmetic right shift of DATA1 by DATA2[SHAMT_W-1:0]
  - 111 reserved: RESULT=0, completes like a single-cycle op
- States: IDLE and EXEC.
- Operand capture: operands and SELECT are latched at the edge where IDLE && START. Later changes to the inputs have no effect on the op in progress.
- Single-cycle ops (FWD, ADD, AND, OR, reserved, and SLL/SRA with amount 0):
  - The result is written at the accepting edge.
  - DONE=1 in cycle n+1, where n is the START cycle.
  - State stays IDLE and BUSY never rises.
- MUL:
  - Accepting edge: A=DATA1, B=DATA2, ACC=0, CNT=WIDTH; go to EXEC with BUSY=1.
  - Each EXEC edge: if B[0], ACC+=A; then A<<=1, B>>=1, CNT-=1.
  - The edge where CNT reaches 0 writes RESULT=ACC (including that edge's add), pulses DONE, returns to IDLE and clears BUSY.
  - Fixed latency: DONE in cycle n+WIDTH+1. BUSY is high for cycles n+1..n+WIDTH. No early termination.
- SLL/SRA with amount k≥1:
  - Accepting edge latches k into CNT and goes to EXEC.
  - Each EXEC edge shifts the working register by one bit. SRA replicates the MSB.
  - The final shift edge writes RESULT and DONE. DONE is in cycle n+k+1; BUSY is high for cycles n+1..n+k.
  - Amount bits above SHAMT_W are ignored.
- Flags:
  - ZERO and OVF update only on the completion edge, together with RESULT.
  - OVF = (A[MSB]==B[MSB]) && (SUM[MSB]!=A[MSB]), for ADD only.
- DONE is a single-cycle pulse. In the DONE cycle the state is IDLE, so a START in that same cycle is accepted (back-to-back ops, no bubble).
- START while BUSY=1 is ignored, not queued.
- RESET and START in the same cycle: RESET wins.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_FWD, OP_ADD, OP_AND, OP_OR, OP_MUL, OP_SLL, OP_SRA, OP_RSVD
  - state encoding: S_IDLE, S_EXEC
- One sub-module, alu_iter_unit, holds the MUL/shift working registers (A, B, ACC, CNT). It takes load/step controls and returns a last-step indication.
- The top level holds the FSM, the single-cycle datapath, and the RESULT/flag registers.

Test Plan:
- WIDTH=8, ADD DATA1=0x05, DATA2=0xFD -> RESULT=0x02, ZERO=0, OVF=0, DONE in cycle n+1, BUSY never 1. Then ADD 0x7F+0x01 -> RESULT=0x80, OVF=1.
- MUL 0x0D×0x0B -> RESULT=0x8F, BUSY high exactly 8 cycles, DONE in cycle n+9. MUL 0x10×0x10 -> RESULT=0x00, ZERO=1.
- SRA DATA1=0x90, DATA2=0x03 -> RESULT=0xF2, DONE in cycle n+4. SLL DATA1=0x81, DATA2=0x08 -> amount 0 -> RESULT=0x81, DONE in cycle n+1.
- Start MUL, toggle START/DATA1/SELECT while BUSY -> all ignored, original product returned. START asserted in the DONE cycle (AND 0xF0&0x3C) -> accepted, RESULT=0x30 next cycle.
- RESET asserted at cycle n+4 of a MUL -> next cycle RESULT=0, ZERO=1, BUSY=0, no DONE. A following FWD 0x5A -> RESULT=0x5A.
- Reserved opcode 111 -> RESULT=0, ZERO=1, DONE in cycle n+1. Rerun the MUL test with WIDTH=16: 0x1234×0x0010 -> 0x2340, DONE in cycle n+17.
